vga_line_fetch: RTL and testbench
=================================

# vga_line_fetch

AXI4 read-burst engine that fetches one display line of packed 12-bit pixels from DDR2 into the VGA line buffer. It sits directly upstream of the `vga` scan-out logic. On each line request from the timing generator, it issues aligned INCR bursts on the memory AXI read channel. It writes every returned 32-bit word, in order, into the line-buffer write port.

## Interface

Parameters:
- MAX_BURST, 16, maximum beats per burst (power of two, 1..256)
- AXI_ID, 0, constant value driven on mem_arid
- LB_AW, 12, line-buffer word-address width; also the width of fetch_words

Ports:
- clk  in  1  memory-interface clock; every port is synchronous to it
- cpu_resetn  in  1  asynchronous, active-low reset
- fetch_start  in  1  single-cycle request pulse; ignored unless the FSM is in IDLE
- fetch_addr  in  32  byte start address; bits [1:0] must be 0
- fetch_words  in  LB_AW  number of 32-bit words to fetch (0..2^LB_AW-1)
- fetch_busy  out  1  high from the cycle after an accepted start through the DONE cycle
- fetch_done  out  1  one-cycle completion pulse
- fetch_err  out  1  sticky error flag; cleared on the next accepted fetch_start
- mem_arid  out  8  AXI_ID
- mem_araddr  out  32  burst start address
- mem_arlen  out  8  burst beats minus 1
- mem_arsize  out  3  constant 3'b010 (4 bytes per beat)
- mem_arburst  out  2  constant 2'b01 (INCR)
- mem_arlock  out  1  constant 0
- mem_arvalid / mem_arready  out / in  1  read-address handshake
- mem_rready  out  1  high only in the DATA state
- mem_rid  in  8  ignored
- mem_rdata  in  32  read data
- mem_rresp  in  2  any nonzero value sets fetch_err
- mem_rlast  in  1  marks the last beat of a burst
- mem_rvalid  in  1  read-data valid
- lb_we  out  1  line-buffer write enable
- lb_addr  out  LB_AW  line-buffer word address
- lb_wdata  out  32  line-buffer write data (two 12-bit pixels, each zero-padded to 16 bits)

## Operation

- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE, on fetch_start:
  - Latch cur_addr = fetch_addr and remaining = fetch_words.
  - Clear the word counter and fetch_err.
  - If fetch_words = 0, go to DONE. Otherwise go to ADDR.
- Burst length: beats = min(remaining, MAX_BURST, (4096 − cur_addr[11:0])/4). A burst never crosses a 4 KB boundary.
- ADDR:
  - Assert mem_arvalid with mem_araddr = cur_addr and mem_arlen = beats−1.
  - All AR fields stay stable until mem_arready is seen.
  - On the handshake, go to DATA.
- DATA:
  - mem_rready = 1.
  - Each beat (mem_rvalid & mem_rready) produces one line-buffer write at the running word counter, after which the counter increments.
  - On the beat with mem_rlast: remaining −= beats, cur_addr += 4·beats. Go to DONE if remaining = 0, otherwise back to ADDR.
  - If the received beat count differs from the expected beats when mem_rlast arrives, set fetch_err. The bookkeeping uses the expected beats, not the received count.
- DONE: pulse fetch_done, then return to IDLE.
- fetch_start while not in IDLE is dropped with no other effect.
- Only one burst is outstanding at a time; there is no AR/R overlap.
- The word counter wraps modulo 2^LB_AW. The requester guarantees fetch_words ≤ line-buffer depth.

## Timing

- Reset: every output is 0 except the constant AXI fields (mem_arid = AXI_ID, mem_arsize = 3'b010, mem_arburst = 2'b01, mem_arlock = 0). The FSM is in IDLE.
- fetch_start in cycle 0 → mem_arvalid and fetch_busy high in cycle 1.
- After an AR handshake in cycle n, mem_rready is high from cycle n+1.
- lb_we/lb_addr/lb_wdata are registered: a beat accepted in cycle k is written in cycle k+1.
- Final beat accepted in cycle k → fetch_done = 1 and the final lb_we both occur in cycle k+1. fetch_busy drops in cycle k+2, and a new start is accepted in cycle k+2.
- fetch_words = 0: fetch_done in cycle 1, no AXI activity.
- Between bursts, rlast in cycle k → next mem_arvalid in cycle k+1.
- Asserting cpu_resetn low at any point immediately forces IDLE and zeroes the outputs. Any in-flight AXI transaction is abandoned; the interconnect is reset by the same reset.

## Structure

- Package vga_fetch_pkg contains:
  - typedef enum fetch_state_t {IDLE, ADDR, DATA, DONE}
  - constants AXI_SIZE_4B = 3'b010 and AXI_BURST_INCR = 2'b01
  - function burst_beats(remaining, addr_lo, max_burst), the 4 KB-aware burst-length computation
- No sub-module; a single flat module.

## Test plan

- Start at 0x0000_0000 with 40 words, MAX_BURST = 16 → three bursts: arlen 15/15/7 at 0x000/0x040/0x080; lb_addr 0..39 with data matching memory; exactly one fetch_done.
- Start at 0x0000_0FF0 with 16 words → arlen 3 at 0xFF0, then arlen 11 at 0x1000; 16 contiguous writes.
- mem_arready held low for 20 cycles → mem_arvalid, mem_araddr and mem_arlen stay constant throughout; the handshake then proceeds.
- Random mem_rvalid gaps over a 640-word fetch → 640 writes, lb_addr contiguous, data in order; fetch_done coincides with the last lb_we.
- mem_rresp = 2'b10 on beat 5 of a 32-word fetch → all 32 words written; fetch_err = 1 at and after fetch_done; the next fetch_start clears it.
- fetch_words = 0 → fetch_done in cycle 1 with no mem_arvalid. cpu_resetn pulsed low mid-DATA → all outputs 0 and the FSM in IDLE; a subsequent fetch completes normally.

Source files
------------

// File: rtl/vga_fetch_pkg.sv
// Shared types and helpers for the VGA line-fetch AXI read engine.
package vga_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } fetch_state_t;

   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   // addr_lo is the word offset inside the current 4 KB page (byte address bits [11:2]).
   function automatic logic [8:0] burst_beats(input logic [31:0] remaining,
                                              input logic [9:0]  addr_lo,
                                              input logic [8:0]  max_burst);
      logic [31:0] lim;
      logic [31:0] to_4k;
      to_4k = 32'd1024 - 32'(addr_lo);
      lim   = remaining;
      if (lim > 32'(max_burst)) lim = 32'(max_burst);
      if (lim > to_4k)          lim = to_4k;
      return 9'(lim);
   endfunction

endpackage

// File: rtl/vga_line_fetch.sv
// Fetches one display line from DDR2 over AXI4 INCR read bursts and streams
// each returned word, in order, into the VGA line-buffer write port.
//
// state | meaning
// IDLE  | waiting for fetch_start
// ADDR  | read-address request presented, waiting for mem_arready
// DATA  | accepting read beats, writing the line buffer
// DONE  | one-cycle completion pulse, back to IDLE
module vga_line_fetch
   import vga_fetch_pkg::*;
#(
   parameter int MAX_BURST = 16,
   parameter int AXI_ID    = 0,
   parameter int LB_AW     = 12
) (
   input  logic             clk,
   input  logic             cpu_resetn,
   input  logic             fetch_start,
   input  logic [31:0]      fetch_addr,
   input  logic [LB_AW-1:0] fetch_words,
   output logic             fetch_busy,
   output logic             fetch_done,
   output logic             fetch_err,
   output logic [7:0]       mem_arid,
   output logic [31:0]      mem_araddr,
   output logic [7:0]       mem_arlen,
   output logic [2:0]       mem_arsize,
   output logic [1:0]       mem_arburst,
   output logic             mem_arlock,
   output logic             mem_arvalid,
   input  logic             mem_arready,
   output logic             mem_rready,
   input  logic [7:0]       mem_rid,
   input  logic [31:0]      mem_rdata,
   input  logic [1:0]       mem_rresp,
   input  logic             mem_rlast,
   input  logic             mem_rvalid,
   output logic             lb_we,
   output logic [LB_AW-1:0] lb_addr,
   output logic [31:0]      lb_wdata
);

   localparam logic [8:0]  MB        = 9'(MAX_BURST);
   localparam logic [31:0] PIX_MASK  = 32'h0FFF_0FFF;

   fetch_state_t     state_q, state_d;
   logic [31:0]      cur_addr_q, cur_addr_d;
   logic [LB_AW-1:0] remaining_q, remaining_d;
   logic [LB_AW-1:0] wcnt_q, wcnt_d;
   logic [8:0]       beats_q, beats_d;
   logic [8:0]       rcv_q, rcv_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             arvalid_q, arvalid_d;
   logic [31:0]      araddr_q, araddr_d;
   logic [7:0]       arlen_q, arlen_d;
   logic             rready_q, rready_d;
   logic             lb_we_q, lb_we_d;
   logic [LB_AW-1:0] lb_addr_q, lb_addr_d;
   logic [31:0]      lb_wdata_q, lb_wdata_d;
   logic             beat;

   logic unused_rid;
   assign unused_rid = ^mem_rid;

   assign beat = mem_rvalid & rready_q;

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      wcnt_d      = wcnt_q;
      beats_d     = beats_q;
      rcv_d       = rcv_q;
      err_d       = err_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      arvalid_d   = arvalid_q;
      araddr_d    = araddr_q;
      arlen_d     = arlen_q;
      rready_d    = rready_q;
      lb_we_d     = 1'b0;
      lb_addr_d   = lb_addr_q;
      lb_wdata_d  = lb_wdata_q;
      case (state_q)
         IDLE: begin
            if (fetch_start) begin
               cur_addr_d  = fetch_addr;
               remaining_d = fetch_words;
               wcnt_d      = '0;
               rcv_d       = '0;
               err_d       = 1'b0;
               busy_d      = 1'b1;
               if (fetch_words == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = ADDR;
                  beats_d   = burst_beats(32'(fetch_words), fetch_addr[11:2], MB);
                  arvalid_d = 1'b1;
                  araddr_d  = fetch_addr;
                  arlen_d   = 8'(beats_d - 9'd1);
               end
            end
         end
         ADDR: begin
            if (mem_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               rcv_d     = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (beat) begin
               lb_we_d    = 1'b1;
               lb_addr_d  = wcnt_q;
               lb_wdata_d = mem_rdata & PIX_MASK;
               wcnt_d     = wcnt_q + 1'b1;
               rcv_d      = rcv_q + 9'd1;
               if (mem_rresp != 2'b00) err_d = 1'b1;
               if (mem_rlast) begin
                  // Bookkeeping advances by the requested length even if the slave miscounted.
                  if (rcv_d != beats_q) err_d = 1'b1;
                  remaining_d = remaining_q - LB_AW'(beats_q);
                  cur_addr_d  = cur_addr_q + (32'(beats_q) << 2);
                  rready_d    = 1'b0;
                  if (remaining_d == '0) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d   = ADDR;
                     beats_d   = burst_beats(32'(remaining_d), cur_addr_d[11:2], MB);
                     arvalid_d = 1'b1;
                     araddr_d  = cur_addr_d;
                     arlen_d   = 8'(beats_d - 9'd1);
                  end
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         wcnt_q      <= '0;
         beats_q     <= '0;
         rcv_q       <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         arlen_q     <= '0;
         rready_q    <= 1'b0;
         lb_we_q     <= 1'b0;
         lb_addr_q   <= '0;
         lb_wdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         wcnt_q      <= wcnt_d;
         beats_q     <= beats_d;
         rcv_q       <= rcv_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         arvalid_q   <= arvalid_d;
         araddr_q    <= araddr_d;
         arlen_q     <= arlen_d;
         rready_q    <= rready_d;
         lb_we_q     <= lb_we_d;
         lb_addr_q   <= lb_addr_d;
         lb_wdata_q  <= lb_wdata_d;
      end
   end

   assign fetch_busy  = busy_q;
   assign fetch_done  = done_q;
   assign fetch_err   = err_q;
   assign mem_arid    = 8'(AXI_ID);
   assign mem_araddr  = araddr_q;
   assign mem_arlen   = arlen_q;
   assign mem_arsize  = AXI_SIZE_4B;
   assign mem_arburst = AXI_BURST_INCR;
   assign mem_arlock  = 1'b0;
   assign mem_arvalid = arvalid_q;
   assign mem_rready  = rready_q;
   assign lb_we       = lb_we_q;
   assign lb_addr     = lb_addr_q;
   assign lb_wdata    = lb_wdata_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch with a small AXI read-slave model.
module tb_vga_line_fetch;
   localparam int LB_AW = 12;

   logic             clk, cpu_resetn, fetch_start;
   logic [31:0]      fetch_addr;
   logic [LB_AW-1:0] fetch_words;
   logic             fetch_busy, fetch_done, fetch_err;
   logic [7:0]       mem_arid, mem_arlen, mem_rid;
   logic [31:0]      mem_araddr, mem_rdata, lb_wdata;
   logic [2:0]       mem_arsize;
   logic [1:0]       mem_arburst, mem_rresp;
   logic             mem_arlock, mem_arvalid, mem_arready, mem_rready;
   logic             mem_rlast, mem_rvalid, lb_we;
   logic [LB_AW-1:0] lb_addr;

   vga_line_fetch #(.MAX_BURST(16), .AXI_ID(0), .LB_AW(LB_AW)) dut (
      .clk(clk), .cpu_resetn(cpu_resetn), .fetch_start(fetch_start),
      .fetch_addr(fetch_addr), .fetch_words(fetch_words),
      .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fetch_err(fetch_err),
      .mem_arid(mem_arid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
      .mem_arsize(mem_arsize), .mem_arburst(mem_arburst), .mem_arlock(mem_arlock),
      .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_rready(mem_rready),
      .mem_rid(mem_rid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
      .mem_rlast(mem_rlast), .mem_rvalid(mem_rvalid),
      .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0]      ar_addr_log[$];
   logic [7:0]       ar_len_log[$];
   logic [LB_AW-1:0] wr_addr_log[$];
   logic [31:0]      wr_data_log[$];
   int   done_cnt = 0;
   logic done_with_we = 1'b0;
   logic err_at_done  = 1'b0;
   int   ar_delay = 0;
   bit   gaps     = 1'b0;
   int   err_beat = -1;
   int   beat_idx = 0;

   logic [31:0] p_addr;
   logic [7:0]  p_len;
   logic        p_valid = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents: pad nibbles are zero so each word is two 12-bit pixels.
   function automatic logic [31:0] mdata(input logic [31:0] a);
      logic [11:0] w;
      w = a[13:2];
      return {4'h0, w ^ 12'h5A5, 4'h0, w + 12'h123};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic clear_logs();
      ar_addr_log.delete();
      ar_len_log.delete();
      wr_addr_log.delete();
      wr_data_log.delete();
      done_cnt = 0;
      beat_idx = 0;
   endtask

   task automatic start(input logic [31:0] addr, input int words,
                        output logic busy1, output logic arv1, output logic done1);
      tick();
      fetch_addr  = addr;
      fetch_words = LB_AW'(words);
      fetch_start = 1'b1;
      tick();
      busy1 = fetch_busy;
      arv1  = mem_arvalid;
      done1 = fetch_done;
      fetch_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(done_cnt != 0), 32'd1);
   endtask

   task automatic check_writes(input string tag, input logic [31:0] base, input int n);
      int m;
      check({tag, "_count"}, 32'(wr_addr_log.size()), 32'(n));
      m = (wr_addr_log.size() < n) ? wr_addr_log.size() : n;
      for (int i = 0; i < m; i++) begin
         check({tag, "_addr"}, 32'(wr_addr_log[i]), 32'(LB_AW'(i)));
         check({tag, "_data"}, wr_data_log[i], mdata(base + 32'(4 * i)));
      end
   endtask

   task automatic check_ar(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
      if (idx < ar_addr_log.size()) begin
         check({tag, "_araddr"}, ar_addr_log[idx], a);
         check({tag, "_arlen"}, 32'(ar_len_log[idx]), 32'(l));
      end else begin
         check({tag, "_missing"}, 32'(ar_addr_log.size()), 32'(idx + 1));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},    32'(fetch_busy),  32'd0);
      check({tag, "_done"},    32'(fetch_done),  32'd0);
      check({tag, "_err"},     32'(fetch_err),   32'd0);
      check({tag, "_arvalid"}, 32'(mem_arvalid), 32'd0);
      check({tag, "_araddr"},  mem_araddr,       32'd0);
      check({tag, "_arlen"},   32'(mem_arlen),   32'd0);
      check({tag, "_rready"},  32'(mem_rready),  32'd0);
      check({tag, "_lb_we"},   32'(lb_we),       32'd0);
      check({tag, "_lb_addr"}, 32'(lb_addr),     32'd0);
      check({tag, "_lb_wdata"}, lb_wdata,        32'd0);
      check({tag, "_arid"},    32'(mem_arid),    32'd0);
      check({tag, "_arsize"},  32'(mem_arsize),  32'd2);
      check({tag, "_arburst"}, 32'(mem_arburst), 32'd1);
      check({tag, "_arlock"},  32'(mem_arlock),  32'd0);
   endtask

   // Monitor: samples at the falling edge, before the slave updates its inputs.
   always @(negedge clk) begin
      if (lb_we) begin
         wr_addr_log.push_back(lb_addr);
         wr_data_log.push_back(lb_wdata);
      end
      if (fetch_done) begin
         done_cnt++;
         done_with_we = lb_we;
         err_at_done  = fetch_err;
      end
      if (cpu_resetn && p_valid && !mem_arready) begin
         check("ar_stable_valid", 32'(mem_arvalid), 32'd1);
         check("ar_stable_addr", mem_araddr, p_addr);
         check("ar_stable_len", 32'(mem_arlen), 32'(p_len));
      end
      p_valid = mem_arvalid;
      p_addr  = mem_araddr;
      p_len   = mem_arlen;
   end

   // AXI read slave: one burst at a time, inputs changed 1 ns after the falling edge.
   initial begin : slave
      logic [31:0] a;
      logic [7:0]  l;
      int guard;
      mem_arready = 1'b0;
      mem_rvalid  = 1'b0;
      mem_rlast   = 1'b0;
      mem_rresp   = 2'b00;
      mem_rdata   = 32'd0;
      mem_rid     = 8'd0;
      forever begin
         @(negedge clk);
         #1;
         if (cpu_resetn && mem_arvalid) begin
            for (int d = 0; d < ar_delay && cpu_resetn; d++) begin
               @(negedge clk);
               #1;
            end
            ar_delay = 0;
            a = mem_araddr;
            l = mem_arlen;
            mem_arready = 1'b1;
            @(negedge clk);
            #1;
            mem_arready = 1'b0;
            ar_addr_log.push_back(a);
            ar_len_log.push_back(l);
            for (int b = 0; b <= int'(l) && cpu_resetn; b++) begin
               if (gaps) begin
                  repeat ($urandom_range(0, 2)) begin
                     @(negedge clk);
                     #1;
                  end
               end
               mem_rvalid = 1'b1;
               mem_rdata  = mdata(a + 32'(4 * b));
               mem_rlast  = (b == int'(l));
               mem_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
               beat_idx++;
               guard = 0;
               while (!mem_rready && cpu_resetn && guard < 100) begin
                  @(negedge clk);
                  #1;
                  guard++;
               end
               @(negedge clk);
               #1;
               mem_rvalid = 1'b0;
               mem_rlast  = 1'b0;
               mem_rresp  = 2'b00;
            end
         end
      end
   end

   initial begin : main
      logic b1, v1, d1;
      int n;
      cpu_resetn  = 1'b0;
      fetch_start = 1'b0;
      fetch_addr  = 32'd0;
      fetch_words = '0;
      #2;
      check_reset_outputs("reset");
      tick();
      tick();
      cpu_resetn = 1'b1;

      // Three bursts from address 0.
      clear_logs();
      start(32'h0, 40, b1, v1, d1);
      check("t1_busy_c1", 32'(b1), 32'd1);
      check("t1_arvalid_c1", 32'(v1), 32'd1);
      check("t1_done_c1", 32'(d1), 32'd0);
      wait_done("t1_done", 500);
      check("t1_done_with_we", 32'(done_with_we), 32'd1);
      tick();
      check("t1_busy_after", 32'(fetch_busy), 32'd0);
      repeat (3) tick();
      check("t1_done_cnt", 32'(done_cnt), 32'd1);
      check("t1_ar_cnt", 32'(ar_addr_log.size()), 32'd3);
      check_ar("t1_b0", 0, 32'h000, 8'd15);
      check_ar("t1_b1", 1, 32'h040, 8'd15);
      check_ar("t1_b2", 2, 32'h080, 8'd7);
      check_writes("t1_wr", 32'h0, 40);

      // 4 KB boundary split.
      clear_logs();
      start(32'h0000_0FF0, 16, b1, v1, d1);
      wait_done("t2_done", 500);
      tick();
      check("t2_ar_cnt", 32'(ar_addr_log.size()), 32'd2);
      check_ar("t2_b0", 0, 32'h0FF0, 8'd3);
      check_ar("t2_b1", 1, 32'h1000, 8'd11);
      check_writes("t2_wr", 32'h0FF0, 16);

      // AR held off for 20 cycles.
      clear_logs();
      ar_delay = 20;
      start(32'h200, 8, b1, v1, d1);
      repeat (10) tick();
      check("t3_arvalid_held", 32'(mem_arvalid), 32'd1);
      check("t3_araddr_held", mem_araddr, 32'h200);
      check("t3_arlen_held", 32'(mem_arlen), 32'd7);
      check("t3_rready_low", 32'(mem_rready), 32'd0);
      wait_done("t3_done", 500);
      tick();
      check_ar("t3_b0", 0, 32'h200, 8'd7);
      check_writes("t3_wr", 32'h200, 8);

      // Long fetch with random rvalid gaps.
      clear_logs();
      gaps = 1'b1;
      start(32'h2000, 640, b1, v1, d1);
      wait_done("t4_done", 8000);
      check("t4_done_with_we", 32'(done_with_we), 32'd1);
      tick();
      gaps = 1'b0;
      check("t4_ar_cnt", 32'(ar_addr_log.size()), 32'd40);
      check("t4_err", 32'(fetch_err), 32'd0);
      check_writes("t4_wr", 32'h2000, 640);

      // SLVERR on the fifth beat.
      clear_logs();
      err_beat = 4;
      start(32'h400, 32, b1, v1, d1);
      wait_done("t5_done", 500);
      check("t5_err_at_done", 32'(err_at_done), 32'd1);
      tick();
      tick();
      err_beat = -1;
      check("t5_err_sticky", 32'(fetch_err), 32'd1);
      check_writes("t5_wr", 32'h400, 32);

      // Zero-length fetch also clears the sticky error.
      clear_logs();
      start(32'h800, 0, b1, v1, d1);
      check("t6_done_c1", 32'(d1), 32'd1);
      check("t6_busy_c1", 32'(b1), 32'd1);
      check("t6_arvalid_c1", 32'(v1), 32'd0);
      check("t6_err_cleared", 32'(fetch_err), 32'd0);
      tick();
      check("t6_busy_after", 32'(fetch_busy), 32'd0);
      check("t6_ar_cnt", 32'(ar_addr_log.size()), 32'd0);

      // Reset in the middle of DATA.
      clear_logs();
      start(32'h0, 32, b1, v1, d1);
      n = 0;
      while (wr_addr_log.size() < 5 && n < 200) begin
         tick();
         n++;
      end
      check("t7_reached_data", 32'(wr_addr_log.size() >= 5), 32'd1);
      cpu_resetn = 1'b0;
      #1;
      check_reset_outputs("t7_rst");
      repeat (3) tick();
      cpu_resetn = 1'b1;
      repeat (2) tick();
      clear_logs();
      start(32'h100, 8, b1, v1, d1);
      check("t7_arvalid_c1", 32'(v1), 32'd1);
      wait_done("t7_done", 500);
      tick();
      check("t7_ar_cnt", 32'(ar_addr_log.size()), 32'd1);
      check_ar("t7_b0", 0, 32'h100, 8'd7);
      check_writes("t7_wr", 32'h100, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
